pixel_streamer: RTL

//  Source end of the classifier's pixel-load interface.
//  - Accepts one 8-bit grayscale frame (WIDTH pixels) over a valid/ready byte stream.
//  - Converts each pixel to BITS-wide Q.FRAC fixed point.
//  - Drives the classifier's counter/input_pixel load bus, then waits for its done flag.
//  - Sits between the host byte source (UART/DMA) and full_connected_layer.

---
 rtl/nn_pkg.sv | 7 +
 rtl/pixel_to_fixed.sv | 15 +
 rtl/pixel_streamer.sv | 89 ++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared states and default dimensions for the classifier front end
package nn_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, DONE} streamer_state_t;
  localparam int IMG_PIXELS = 784;
  localparam int Q_FRAC     = 12;
  localparam int PIX_BITS   = 8;
endpackage

// File: rtl/pixel_to_fixed.sv
// pixel_to_fixed: 8-bit grey to BITS-wide Q.FRAC; PIXEL_NORM_EN selects p/255 scaling, else raw integer
module pixel_to_fixed #(
  parameter int BITS = 24,
  parameter int FRAC = 12
) (
  input  logic [7:0]      i_pix,
  output logic [BITS-1:0] o_fixed
);
`ifdef PIXEL_NORM_EN
  // p*(2^FRAC)/256 plus a small correction term so 255 lands just under 1.0
  assign o_fixed = (BITS'(i_pix) << (FRAC - 8)) + (BITS'(i_pix) >> (16 - FRAC));
`else
  assign o_fixed = BITS'(i_pix) << FRAC;
`endif
endmodule

// File: rtl/pixel_streamer.sv
// pixel_streamer: streams one frame into the classifier load bus and waits for its done flag
// Conversion chosen by PIXEL_NORM_EN inside pixel_to_fixed.
module pixel_streamer
  import nn_pkg::*;
#(
  parameter int BITS       = 24,
  parameter int FRAC       = Q_FRAC,
  parameter int WIDTH      = IMG_PIXELS,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            pix_valid,
  input  logic [7:0]      pix_data,
  output logic            pix_ready,
  input  logic            layer_done,
  output logic            layer_reset_n,
  output logic [9:0]      counter,
  output logic [BITS-1:0] input_pixel,
  output logic            busy,
  output logic            frame_done,
  output logic            timeout_err
);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 2);

  if (WIDTH > 1023 || WIDTH < 1) $error("WIDTH must be 1..1023");
  if (CLR_CYCLES < 1) $error("CLR_CYCLES must be >= 1");

  streamer_state_t r_state, w_next;
  logic [CW-1:0]   r_clr;
  logic [TW-1:0]   r_wait;
  logic [BITS-1:0] w_conv;
  logic            w_accept, w_last, w_clr_end, w_tmo;

  pixel_to_fixed #(.BITS(BITS), .FRAC(FRAC)) u_conv (.i_pix(pix_data), .o_fixed(w_conv));

  assign pix_ready     = (r_state == STREAM) && (counter != 10'(WIDTH));
  assign layer_reset_n = (r_state != CLEAR);
  assign busy          = (r_state != IDLE);
  assign frame_done    = (r_state == DONE);
  assign w_accept      = pix_valid & pix_ready;
  assign w_last        = (counter == 10'(WIDTH - 1));
  assign w_clr_end     = (r_clr == CW'(CLR_CYCLES - 1));
  assign w_tmo         = (TIMEOUT != 0) && (r_wait == TW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CLEAR : IDLE;
      CLEAR:   w_next = w_clr_end ? STREAM : CLEAR;
      STREAM:  w_next = (w_accept && w_last) ? WAIT : STREAM;
      WAIT:    w_next = layer_done ? DONE : (w_tmo ? IDLE : WAIT);
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_clr       <= '0;
      r_wait      <= '0;
      counter     <= '0;
      input_pixel <= '0;
      timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_clr   <= (r_state == CLEAR) ? r_clr + 1'b1 : '0;
      r_wait  <= (r_state == WAIT) ? r_wait + 1'b1 : '0;
      if (r_state == IDLE && start) begin
        timeout_err <= 1'b0;
        counter     <= '0;
      end
      if (w_accept) begin
        input_pixel <= w_conv;
        counter     <= counter + 10'd1;
      end
      if (r_state == DONE) counter <= '0;
      // done beats timeout when both land in the same cycle
      if (r_state == WAIT && !layer_done && w_tmo) begin
        timeout_err <= 1'b1;
        counter     <= '0;
      end
    end
  end
endmodule
